// File: rtl/lap_timer_pkg.sv
// lap_timer_pkg: shared BCD time types, digit limits and preset validation
package lap_timer_pkg;
  typedef logic [3:0] bcd_t;
  typedef bcd_t [5:0] time_t;
  localparam bcd_t DIGIT_TEST = 4'h8;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_TENS_MAX = 4'd5;
  localparam bcd_t UNIT_MAX = 4'd9;
  function automatic logic preset_ok(input time_t p, input int hr_max);
    preset_ok = p[0] <= UNIT_MAX && p[1] <= SEC_TENS_MAX && p[2] <= UNIT_MAX &&
                p[3] <= MIN_TENS_MAX && p[4] <= UNIT_MAX && p[5] <= UNIT_MAX &&
                (int'(p[5]) * 10 + int'(p[4])) <= hr_max;
  endfunction
endpackage

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: HH:MM:SS BCD up/down counter with carry/borrow chain, hour wrap and zero detect
module bcd_time_counter
  import lap_timer_pkg::*;
#(
  parameter int HR_MAX = 99
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  clear,
  input  logic  load,
  input  logic  step,
  input  logic  down,
  input  time_t preset,
  output time_t count,
  output logic  zero
);
  localparam time_t DIG_MAX = 24'h995959;
  localparam bcd_t H1_MAX = bcd_t'(HR_MAX / 10);
  localparam bcd_t H0_MAX = bcd_t'(HR_MAX % 10);
  logic [4:0] at_lim;
  logic [5:0] c;
  logic hr_wrap;
  time_t raw;
  // c[i]: every lower digit rolls over, so digit i moves this step
  always_comb begin
    for (int i = 0; i < 5; i++) at_lim[i] = down ? count[i] == 4'd0 : count[i] == DIG_MAX[i];
    c[0] = 1'b1;
    for (int i = 1; i < 6; i++) c[i] = c[i-1] & at_lim[i-1];
    for (int i = 0; i < 5; i++)
      raw[i] = !c[i] ? count[i] : at_lim[i] ? (down ? DIG_MAX[i] : 4'd0) :
               down ? count[i] - 4'd1 : count[i] + 4'd1;
    raw[5] = !c[5] ? count[5] : down ? count[5] - 4'd1 : count[5] + 4'd1;
    hr_wrap = !down && c[4] && count[5] == H1_MAX && count[4] == H0_MAX;
  end
  always_ff @(posedge clock)
    if (!reset || clear) count <= '0;
    else if (load) count <= preset;
    else if (step) count <= hr_wrap ? '0 : raw;
  assign zero = count == '0;
endmodule

// File: rtl/seg_decoder.sv
// seg_decoder: BCD digit to active-high gfedcba 7-segment pattern, blank for non-decimal codes
module seg_decoder (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb
    case (bcd)
      4'd0: seg = 7'h3f;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5b;
      4'd3: seg = 7'h4f;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6d;
      4'd6: seg = 7'h7d;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7f;
      4'd9: seg = 7'h6f;
      default: seg = 7'h00;
    endcase
endmodule

// File: rtl/lap_timer.sv
// lap_timer: HH:MM:SS stopwatch/countdown with preset load, lap freeze and 7-segment display
module lap_timer
  import lap_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int HR_MAX = 99
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        finish,
  input  logic        run,
  input  logic        mode,
  input  logic        load,
  input  logic [23:0] preset_bcd,
  input  logic        lap,
  output logic [6:0]  hr1,
  output logic [6:0]  hr0,
  output logic [6:0]  min1,
  output logic [6:0]  min0,
  output logic [6:0]  sec1,
  output logic [6:0]  sec0,
  output logic [23:0] time_bcd,
  output logic        done,
  output logic        load_err
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
  logic [PW-1:0] pre;
  logic en, tick, valid, load_ok, step, zero, frozen;
  time_t count, lap_val, disp;
  logic [6:0] segs [6];
  assign en = run && !(mode && done);
  assign tick = en && pre == PRE_LAST;
  assign valid = preset_ok(preset_bcd, HR_MAX);
  assign load_ok = load && !finish && valid;
  assign step = tick && !finish && !load_ok && !(mode && zero);
  bcd_time_counter #(.HR_MAX(HR_MAX)) u_cnt (
    .clock, .reset, .clear(finish), .load(load_ok), .step, .down(mode),
    .preset(preset_bcd), .count, .zero
  );
  always_ff @(posedge clock)
    if (!reset || finish || load_ok || tick) pre <= '0;
    else if (en) pre <= pre + 1'b1;
  // a down tick from 00:00:01 lands on zero; from 00:00:00 it only flags
  always_ff @(posedge clock)
    if (!reset || finish || load_ok || !mode) done <= 1'b0;
    else if (tick && (zero || count == time_t'(24'h000001))) done <= 1'b1;
  always_ff @(posedge clock)
    load_err <= reset && !finish && load && !valid;
  always_ff @(posedge clock)
    if (!reset) begin
      frozen <= 1'b0;
      lap_val <= '0;
    end else if (finish || load_ok) frozen <= 1'b0;
    else if (lap) begin
      frozen <= !frozen;
      if (!frozen) lap_val <= count;
    end
  always_ff @(posedge clock)
    if (!reset) disp <= '0;
    else if (finish) disp <= {6{DIGIT_TEST}};
    else disp <= frozen ? lap_val : count;
  assign time_bcd = disp;
  for (genvar d = 0; d < 6; d++) begin : g_seg
    seg_decoder u_dec (.bcd(disp[d]), .seg(segs[d]));
  end
  assign {hr1, hr0, min1, min0, sec1, sec0} = {segs[5], segs[4], segs[3], segs[2], segs[1], segs[0]};
endmodule

// File: doc/lap_timer.md
Name: lap_timer

Overview:
- Parametrised HH:MM:SS stopwatch/countdown for the board display path.
- Successor to the fixed 50 MHz count-up timer.
- Adds configurable tick rate, hour limit, count-down mode with done flag, preset load, and lap (display freeze) capture.
- Drives six 7-segment digits through the existing seg_decoder and exposes the displayed time as raw BCD for debug/verification.

Parameters:
- TICKS_PER_SEC, 50000000: clock cycles per counted second; legal range ≥ 2.
- HR_MAX, 99: highest hour value; legal range 1..99; up-count wraps after HR_MAX:59:59.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- finish  in  1  level; forces all digits to 8 (display test) and clears the count
- run  in  1  level; counting enabled while high
- mode  in  1  0 = count up, 1 = count down
- load  in  1  one-cycle pulse; loads preset_bcd into the counter
- preset_bcd  in  24  {h1,h0,m1,m0,s1,s0}, 4 bits each
- lap  in  1  one-cycle pulse; toggles display freeze
- hr1, hr0, min1, min0, sec1, sec0  out  7 each  segment patterns from seg_decoder
- time_bcd  out  24  displayed BCD, same packing as preset_bcd
- done  out  1  sticky; count-down reached 00:00:00
- load_err  out  1  one-cycle pulse; preset rejected

Behaviour:
- Input priority per clock edge: !reset > finish > load > lap/tick.
- Reset (reset == 0):
  - counter, prescaler and lap register cleared; freeze off.
  - done = 0, load_err = 0, time_bcd = 0, segment outputs = seg_decoder(0).
  - Reset mid-count discards all state.
- finish == 1:
  - every displayed digit = 4'h8 (time_bcd = 24'h888888).
  - counter, prescaler, done and freeze cleared.
  - Held for as long as finish is high; normal live display of 00:00:00 resumes the cycle after finish drops.
- Prescaler:
  - 0..TICKS_PER_SEC-1; advances only while run = 1 and not (mode = 1 and done = 1).
  - tick = prescaler at TICKS_PER_SEC-1; the prescaler returns to 0 on that cycle.
  - Exactly TICKS_PER_SEC enabled cycles per tick.
  - run = 0 holds the prescaler (pause, not clear).
- Up count, applied on tick:
  - s0 9→0 carries to s1; s1 5→0 carries to m0; m0 9→0 carries to m1; m1 5→0 carries to hours.
  - Hours increment as a 2-digit BCD value; HR_MAX:59:59 → 00:00:00.
- Down count, applied on tick:
  - Mirror borrow chain; borrows load s0 = 9, s1 = 5, m0 = 9, m1 = 5.
  - Tick reaching 00:00:00 sets done the same cycle; counting then stops with the prescaler held at 0.
  - Starting down-count from 00:00:00 sets done on the first tick without a decrement.
- done is cleared by reset, finish, an accepted load, or mode = 0.
- load:
  - Preset is valid when every unit digit ≤ 9, s1 ≤ 5, m1 ≤ 5, and hours ≤ HR_MAX.
  - Valid: counter = preset, prescaler = 0, done = 0.
  - Invalid: nothing changes; load_err pulses high the next cycle for one cycle.
  - A load in the same cycle as a tick wins; the tick is lost.
- lap:
  - When not frozen: capture the counter value present before any same-cycle tick, and freeze the display on it.
  - When frozen: release; the display returns to live the next cycle.
  - The counter keeps running while frozen. finish and an accepted load also release the freeze.
- mode change: takes effect at the next tick; the prescaler is not disturbed.
- Latency:
  - time_bcd is registered and updates one cycle after the counter or capture change.
  - Segment outputs are combinational from time_bcd.
- All counter arithmetic is 4-bit per digit; never produces A–F codes.

Decomposition:
- Package lap_timer_pkg:
  - BCD digit typedef (4 bits) and packed time typedef (6 digits).
  - Constants: DIGIT_TEST = 4'h8, SEC_TENS_MAX = 5, MIN_TENS_MAX = 5.
  - Function for preset validation.
- Sub-module bcd_time_counter: up/down BCD chain with carry/borrow, HR_MAX wrap, zero detect.
- Top level holds the prescaler, load/lap/finish control, display register and six seg_decoder instances.

Test Plan (TICKS_PER_SEC = 4, HR_MAX = 23):
- Reset, then run = 1 for 40 cycles, mode = 0 → time_bcd = 24'h000010; done = 0; tick every 4 cycles.
- Load 24'h235959, run up one tick → 24'h000000; run = 0 mid-second holds value and prescaler, and counting resumes with the remaining cycles.
- Load 24'h000002, mode = 1, run 8 cycles → 000001 then 000000, done = 1; a further 20 cycles leaves both unchanged.
- Load 24'h006000 (invalid s… m1 = 6) and load 24'h240000 → load_err one-cycle pulse each; counter unchanged.
- lap at time 000003 on a tick cycle → display frozen at 000003 while the counter reaches 000007; second lap → time_bcd = 000007 next cycle.
- finish asserted mid-count for 3 cycles → time_bcd = 888888 throughout, then 000000; reset = 0 during down count → all zero, done = 0.
